// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the arbiters in front of the 32 x 16-bit FIFO.
package fifo_arb_pkg;

    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    typedef logic [DATA_W-1:0] fifo_data_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request after last_grant, wrapping modulo N.
// Purely combinational with zero latency; the caller qualifies the result with any.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] pick,
    output logic          any
);

    logic [IW-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        // Walk from the farthest offset inward so the nearest requester is the last to win.
        for (int off = N; off >= 1; off--) begin
            idx = IW'((int'(last_grant) + off) % N);
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the FIFO write port: grant one cycle after a request, bursts of up to MAX_BURST beats.
// Data path is combinational; fifo_full stalls the owner in place and blocks new grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4,
    localparam int IW       = $clog2(NREQ),
    localparam int CW       = $clog2(MAX_BURST + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_w_req,
    output logic [DW-1:0]        fifo_in_data,
    output logic [IW-1:0]        grant_id,
    output logic                 busy
);

    arb_state_e    state, state_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [IW-1:0] last_grant, last_grant_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;

    logic [DW-1:0] slot [NREQ];
    logic [IW-1:0] pick;
    logic          any_req;
    logic          owner_vld;
    logic          xfer;
    logic          last_beat;

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DW +: DW];
    end

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .any        (any_req)
    );

    assign busy       = (state == BURST);
    assign owner_vld  = req_valid[owner];
    // The FIFO memory writes on w_req even when full, so full must gate every transfer.
    assign xfer       = busy && owner_vld && !fifo_full;
    assign last_beat  = (beat_cnt == CW'(MAX_BURST - 1));

    assign fifo_w_req   = xfer;
    assign fifo_in_data = xfer ? slot[owner] : '0;
    assign req_ready    = (busy && !fifo_full) ? (NREQ'(1) << owner) : '0;
    assign grant_id     = owner;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (any_req && !fifo_full) begin
                    state_nxt    = BURST;
                    owner_nxt    = pick;
                    beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (!owner_vld) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = owner;
                end else if (xfer) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (last_beat) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = owner;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= IW'(NREQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural 32-deep FIFO model, scenario tasks and a randomized fairness run.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 16;
    localparam int MAX_BURST = 4;
    localparam int IW        = 2;
    localparam int DEPTH     = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                fifo_full;
    logic                fifo_w_req;
    logic [DW-1:0]       fifo_in_data;
    logic [IW-1:0]       grant_id;
    logic                busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    logic model_full = 1'b0;
    logic ovr_en = 1'b0, ovr_val = 1'b0, rd_en = 1'b0, clr = 1'b0;
    logic cap_wr, cap_rd;
    logic [DW-1:0] cap_dat;
    int viol_wr_full = 0, viol_ready = 0, viol_data = 0;

    assign fifo_full = ovr_en ? ovr_val : model_full;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_w_req   (fifo_w_req),
        .fifo_in_data (fifo_in_data),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    // FIFO model: capture mid-cycle, apply just after the edge.
    always begin
        @(negedge clock);
        cap_wr  = fifo_w_req;
        cap_dat = fifo_in_data;
        cap_rd  = rd_en;
        @(posedge clock);
        #1;
        if (clr) begin
            fifo_q.delete();
        end else begin
            if (cap_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (cap_wr && fifo_q.size() < DEPTH) fifo_q.push_back(cap_dat);
        end
        model_full = (fifo_q.size() >= DEPTH);
    end

    // Protocol rules that must hold in every out-of-reset cycle.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (fifo_w_req && fifo_full) viol_wr_full++;
            if ($countones(req_ready) > 1 || (req_ready != '0 && !busy)) viol_ready++;
            if (fifo_w_req !== |(req_valid & req_ready)) viol_data++;
            else if (fifo_w_req) begin
                for (int i = 0; i < NREQ; i++)
                    if (req_valid[i] && req_ready[i] && fifo_in_data !== req_data[i*DW +: DW]) viol_data++;
            end else if (fifo_in_data !== '0) viol_data++;
        end
    end

    task automatic next();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    function automatic logic [DW-1:0] mk(int id, int seq);
        return DW'((id << 12) | (seq & 'hfff));
    endfunction

    task automatic set_data(int id, logic [DW-1:0] d);
        req_data[id*DW +: DW] = d;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_data  = '0;
        rd_en     = 1'b0;
        ovr_en    = 1'b0;
        ovr_val   = 1'b0;
        clr       = 1'b1;
        reset     = 1'b0;
        next();
        clr   = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        clr       = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_data(i, DW'($urandom));
        for (int e = 0; e < 2; e++) begin
            next();
            settle();
            checks++;
            if ({req_ready, fifo_w_req, fifo_in_data, grant_id, busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs edge%0d: ready=%b w_req=%b data=%h grant=%0d busy=%b, required all zero",
                         e, req_ready, fifo_w_req, fifo_in_data, grant_id, busy);
            end
        end
        next();
        reset = 1'b1;
        clr   = 1'b0;
        settle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b required 0", busy);
        end
        next();
        settle();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: busy=%b grant=%0d ready=%b required 1/0/0001", busy, grant_id, req_ready);
        end
        req_valid = '0;
        next();
    endtask

    task automatic test_round_robin();
        int cnt[NREQ];
        int exp_owner;
        bit exp_wr;
        do_reset();
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        req_valid = '1;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NREQ; i++) set_data(i, mk(i, cnt[i]));
            settle();
            exp_wr    = (t % 5) != 0;
            exp_owner = (t == 0) ? 0 : ((t - 1) / 5) % NREQ;
            checks++;
            if (fifo_w_req !== exp_wr ||
                (exp_wr && (fifo_in_data !== mk(exp_owner, cnt[exp_owner]) || grant_id !== IW'(exp_owner)))) begin
                errors++;
                $display("FAIL rr_cycle%0d: w_req=%b grant=%0d data=%h required w_req=%b grant=%0d data=%h",
                         t, fifo_w_req, grant_id, fifo_in_data, exp_wr, exp_owner, mk(exp_owner, cnt[exp_owner]));
            end
            for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) cnt[i]++;
            next();
        end
        req_valid = '0;
        next();
        checks++;
        if (fifo_q.size() != 20) begin
            errors++;
            $display("FAIL rr_fifo_count: got %0d entries required 20", fifo_q.size());
        end
        for (int k = 0; k < 20 && k < fifo_q.size(); k++) begin
            checks++;
            if (fifo_q[k] !== mk((k / 4) % NREQ, (k / 16) * 4 + k % 4)) begin
                errors++;
                $display("FAIL rr_fifo_entry%0d: got %h required %h", k, fifo_q[k], mk((k / 4) % NREQ, (k / 16) * 4 + k % 4));
            end
        end
    endtask

    task automatic test_drop();
        int exp;
        for (int c = 0; c < 2; c++) begin
            do_reset();
            req_valid = 4'b0100;
            settle();
            next();
            for (int b = 0; b < 2; b++) begin
                set_data(2, mk(2, b));
                settle();
                checks++;
                if (!(fifo_w_req === 1'b1 && grant_id === 2'd2 && fifo_in_data === mk(2, b))) begin
                    errors++;
                    $display("FAIL drop_beat%0d: w_req=%b grant=%0d data=%h required 1/2/%h", b, fifo_w_req, grant_id, fifo_in_data, mk(2, b));
                end
                next();
            end
            req_valid = (c == 0) ? 4'b1001 : 4'b0001;
            settle();
            checks++;
            if (busy !== 1'b1 || fifo_w_req !== 1'b0) begin
                errors++;
                $display("FAIL drop_cycle: busy=%b w_req=%b required 1/0", busy, fifo_w_req);
            end
            next();
            settle();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL drop_idle: busy=%b required 0", busy);
            end
            next();
            settle();
            exp = (c == 0) ? 3 : 0;
            checks++;
            if (busy !== 1'b1 || grant_id !== IW'(exp)) begin
                errors++;
                $display("FAIL drop_next_grant case%0d: busy=%b grant=%0d required 1/%0d", c, busy, grant_id, exp);
            end
        end
        req_valid = '0;
        next();
    endtask

    task automatic test_full();
        int sent = 0;
        int cyc  = 0;
        int bad  = 0;
        bit got  = 0;
        do_reset();
        req_valid = 4'b0010;
        while (sent < DEPTH && cyc < 200) begin
            set_data(1, mk(1, sent));
            settle();
            if (req_valid[1] && req_ready[1]) sent++;
            next();
            cyc++;
        end
        checks++;
        if (sent != DEPTH) begin
            errors++;
            $display("FAIL full_fill: accepted %0d beats required %0d", sent, DEPTH);
        end
        set_data(1, mk(1, DEPTH));
        for (int t = 0; t < 4; t++) begin
            settle();
            checks++;
            if (fifo_full !== 1'b1 || fifo_w_req !== 1'b0 || req_ready !== '0) begin
                errors++;
                $display("FAIL full_hold%0d: full=%b w_req=%b ready=%b required 1/0/0000", t, fifo_full, fifo_w_req, req_ready);
            end
            next();
        end
        rd_en = 1'b1;
        settle();
        next();
        rd_en = 1'b0;
        cyc = 0;
        while (!got && cyc < 4) begin
            settle();
            if (req_valid[1] && req_ready[1]) begin
                got = 1;
                checks++;
                if (fifo_in_data !== mk(1, DEPTH)) begin
                    errors++;
                    $display("FAIL full_resume_data: got %h required %h", fifo_in_data, mk(1, DEPTH));
                end
            end
            next();
            cyc++;
        end
        req_valid = '0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL full_resume: beat 33 not accepted within 4 cycles");
        end
        next();
        checks++;
        if (fifo_q.size() != DEPTH) begin
            errors++;
            $display("FAIL full_fifo_count: got %0d required %0d", fifo_q.size(), DEPTH);
        end
        for (int k = 0; k < fifo_q.size(); k++) if (fifo_q[k] !== mk(1, k + 1)) bad++;
        checks++;
        if (bad != 0 || fifo_q.size() == 0 || fifo_q[fifo_q.size() - 1] !== mk(1, DEPTH)) begin
            errors++;
            $display("FAIL full_fifo_order: %0d misplaced entries, last entry must be %h", bad, mk(1, DEPTH));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0010;
        settle();
        next();
        for (int b = 0; b < 2; b++) begin
            set_data(1, mk(1, b));
            settle();
            checks++;
            if (fifo_w_req !== 1'b1 || grant_id !== 2'd1) begin
                errors++;
                $display("FAIL rstmid_beat%0d: w_req=%b grant=%0d required 1/1", b, fifo_w_req, grant_id);
            end
            next();
        end
        reset     = 1'b0;
        req_valid = 4'b0011;
        settle();
        next();
        reset = 1'b1;
        settle();
        checks++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL rstmid_abandon: busy=%b ready=%b required 0/0000", busy, req_ready);
        end
        next();
        settle();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_regrant: busy=%b grant=%0d required 1/0", busy, grant_id);
        end
        req_valid = '0;
        next();
    endtask

    task automatic test_full_toggle();
        int beats = 0;
        int wr_full = 0;
        do_reset();
        ovr_en    = 1'b1;
        req_valid = 4'b1000;
        for (int t = 0; t < 24; t++) begin
            ovr_val = t[0];
            set_data(3, mk(3, beats));
            settle();
            if (fifo_w_req && fifo_full) wr_full++;
            if (req_valid[3] && req_ready[3]) beats++;
            next();
        end
        req_valid = '0;
        ovr_en    = 1'b0;
        next();
        checks++;
        if (wr_full != 0) begin
            errors++;
            $display("FAIL toggle_wr_while_full: %0d writes while full required 0", wr_full);
        end
        checks++;
        if (beats != 9) begin
            errors++;
            $display("FAIL toggle_beats: got %0d required 9", beats);
        end
        checks++;
        if (fifo_q.size() != 9 || fifo_q[fifo_q.size() - 1] !== mk(3, 8)) begin
            errors++;
            $display("FAIL toggle_fifo: %0d entries required 9 ending in %h", fifo_q.size(), mk(3, 8));
        end
    endtask

    task automatic test_random();
        int rem[NREQ], idle[NREQ], seq[NREQ], wait_cnt[NREQ];
        int max_wait = 0, max_burst = 0, run = 0, total = 0;
        logic [NREQ-1:0] prev_valid = '0;
        bit prev_busy = 0;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; seq[i] = 0; wait_cnt[i] = 0;
            idle[i] = $urandom_range(0, 3);
        end
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] == 0) begin
                    if (idle[i] > 0) idle[i]--;
                    else rem[i] = $urandom_range(1, 7);
                end
                req_valid[i] = (rem[i] > 0);
                set_data(i, mk(i, seq[i]));
            end
            rd_en = (fifo_q.size() > 0) && ((t < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            settle();
            if (busy && !prev_busy) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (prev_valid[i] && i != int'(grant_id)) begin
                        wait_cnt[i]++;
                        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                    end
                end
                wait_cnt[grant_id] = 0;
                run = 0;
            end
            for (int i = 0; i < NREQ; i++) if (!req_valid[i]) wait_cnt[i] = 0;
            if (fifo_w_req) begin
                run++;
                total++;
                if (run > max_burst) max_burst = run;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    seq[i]++;
                    rem[i]--;
                    if (rem[i] == 0) idle[i] = $urandom_range(0, 4);
                end
            end
            prev_valid = req_valid;
            prev_busy  = busy;
            next();
        end
        req_valid = '0;
        rd_en     = 1'b0;
        next();
        checks++;
        if (max_wait > NREQ - 1) begin
            errors++;
            $display("FAIL rand_fairness: requester waited %0d grants required <= %0d", max_wait, NREQ - 1);
        end
        checks++;
        if (max_burst != MAX_BURST) begin
            errors++;
            $display("FAIL rand_burst_len: longest burst %0d required %0d", max_burst, MAX_BURST);
        end
        checks++;
        if (total < 50) begin
            errors++;
            $display("FAIL rand_progress: %0d transfers required >= 50", total);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol_wr_full != 0) begin
            errors++;
            $display("FAIL inv_wr_while_full: %0d cycles required 0", viol_wr_full);
        end
        checks++;
        if (viol_ready != 0) begin
            errors++;
            $display("FAIL inv_ready_onehot: %0d cycles required 0", viol_ready);
        end
        checks++;
        if (viol_data != 0) begin
            errors++;
            $display("FAIL inv_datapath: %0d cycles required 0", viol_data);
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        test_reset();
        test_round_robin();
        test_drop();
        test_full();
        test_reset_mid();
        test_full_toggle();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the 32-entry, 16-bit `fifo` between up to NREQ producers. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `w_req`/`in_data`. It sits directly in front of the FIFO's write side and is the only block permitted to drive `w_req`.

## Interface
Parameters:
- `NREQ`, 4 — number of producers, 2..8
- `DW`, 16 — data width; must equal the FIFO data width
- `MAX_BURST`, 4 — maximum beats per grant, 1..16

Ports:
- `clock`  in  1  — single clock, rising edge
- `reset`  in  1  — synchronous, active-low; sampled on the `clock` rising edge; 0 = reset
- `req_valid`  in  NREQ  — producer i has a beat on `req_data` slice i
- `req_data`  in  NREQ*DW  — producer i data in bits [i*DW +: DW]
- `req_ready`  out  NREQ  — one-hot or zero; beat i accepted when valid[i] && ready[i]
- `fifo_full`  in  1  — FIFO `full` flag
- `fifo_w_req`  out  1  — drives FIFO `w_req`
- `fifo_in_data`  out  DW  — drives FIFO `in_data`
- `grant_id`  out  $clog2(NREQ)  — current owner index; valid when `busy`
- `busy`  out  1  — state is BURST

## Operation
- States: IDLE, BURST. Registers: `owner`, `last_grant`, `beat_cnt` ($clog2(MAX_BURST+1) bits).
- IDLE:
  - If any `req_valid` and !`fifo_full`: pick the first requester scanning from `last_grant+1` upward, wrapping modulo NREQ.
  - Then `owner <= pick`, `beat_cnt <= 0`, go to BURST.
  - No beat is accepted in IDLE: `req_ready` = 0 and `fifo_w_req` = 0.
- BURST:
  - `req_ready[owner]` = !`fifo_full`; all other ready bits are 0.
  - `fifo_w_req` = `req_valid[owner]` && !`fifo_full`. This is the transfer condition.
  - `fifo_in_data` = `req_data[owner]` when `fifo_w_req`, else 0.
  - On transfer: `beat_cnt` increments.
- BURST exit to IDLE with `last_grant <= owner`:
  - the transfer is the MAX_BURST-th beat, or
  - `req_valid[owner]` is 0 in any BURST cycle, even while full.
- Full mid-burst: stall in BURST; no transfer and `beat_cnt` holds.
- `fifo_w_req` is never 1 while `fifo_full` = 1. The FIFO memory writes on `w_req` regardless of `full`, so this rule is mandatory.
- Round-robin fairness: a requester continuously valid is granted within NREQ-1 other grants.
- Reset mid-burst: the burst is abandoned and state, counters and pointers are restored at the next edge. Producers must re-present any beat not yet handshaken.

## Timing
Reset values (while `reset` = 0 at an edge):
- state IDLE
- `last_grant` = NREQ-1, so requester 0 has first priority
- `owner` = 0, `beat_cnt` = 0
- `req_ready` = 0, `fifo_w_req` = 0, `fifo_in_data` = 0, `grant_id` = 0, `busy` = 0

Cycle behaviour:
- Grant latency: valid seen in IDLE at edge N; BURST from edge N+1; first beat can be accepted in cycle N+1.
- Data path is combinational: `fifo_in_data` and `fifo_w_req` follow the owner's inputs in the same cycle. The FIFO captures them at the next edge.
- Peak throughput: MAX_BURST beats followed by one IDLE bubble cycle.
- Back-to-back: the last beat and another requester's valid in the same cycle give IDLE next cycle, then the new grant.
- `fifo_full` rising in the same cycle as the owner's valid: no transfer that cycle.

## Structure
- Package `fifo_arb_pkg`:
  - state enum `arb_state_e` {IDLE, BURST}
  - `typedef logic [DW-1:0] fifo_data_t` with default DW = 16
  - `FIFO_DEPTH` = 32
- Sub-module `rr_pick`: combinational round-robin picker. Inputs: request vector and `last_grant`. Outputs: `pick` index and `any`. It is reused later on the read side.

## Test plan
- Reset: hold `reset` = 0 for 2 edges with all valid high → all outputs 0, `busy` = 0; release → requester 0 granted first.
- All 4 requesters continuously valid, FIFO not full, MAX_BURST = 4 → grant order 0,1,2,3,0; 4 beats each; one bubble between bursts; FIFO receives the data in that order.
- Owner 2 valid for 2 beats then drops → BURST ends after 2 beats; next grant goes to 3 if valid, else 0.
- Write 32 beats with no reads → `fifo_full` = 1; `fifo_w_req` and `req_ready` stay 0 with the pending valid held. One FIFO read → the beat is accepted next cycle, and the 33rd value is read out last, uncorrupted.
- `reset` asserted in BURST after beat 2 of requester 1 → `busy` = 0 next cycle; the next grant goes to requester 0.
- Single requester 3 valid with `fifo_full` toggling every cycle → beats are transferred only in non-full cycles, and no `fifo_w_req` occurs while full.
